// File: rtl/combo_lock_fsm.sv
// Parametrised combination-lock controller: compares a DIGITS-long strobed digit
// sequence against a programmable code, reports open/error, counts consecutive
// failures and holds a timed lockout after MAX_FAILS failed attempts.
module combo_lock_fsm #(
    parameter int unsigned DIGITS         = 6,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [DIGIT_W-1:0]                 digit_in,
    input  logic                               digit_valid,
    input  logic [DIGITS*DIGIT_W-1:0]          code,
    input  logic                               relock,
    output logic                               open,
    output logic                               error,
    output logic                               lockout,
    output logic [$clog2(DIGITS+1)-1:0]        digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
    output logic [1:0]                         state
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    // +1 keeps the timer at least one bit wide when LOCKOUT_CYCLES == 1
    localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StEntry   = 2'd0,
        StOpen    = 2'd1,
        StError   = 2'd2,
        StLockout = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     dc_q, dc_d;
    logic [FW-1:0]     fc_q, fc_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              mis_q, mis_d;
    logic              open_q, error_q, lockout_q;

    logic [DIGIT_W-1:0] code_digit;
    logic               digit_miss;
    logic               last_digit;
    logic [31:0]        fails_inc;

    // Select the code digit that the next strobe is compared against
    always_comb begin
        code_digit = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (dc_q == CW'(i)) begin
                code_digit = code[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_miss = (digit_in != code_digit);
    assign last_digit = (dc_q == CW'(DIGITS - 1));
    assign fails_inc  = 32'(fc_q) + 32'd1;

    // Next-state logic for the lock FSM, attempt counters and lockout timer
    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        fc_d    = fc_q;
        timer_d = timer_q;
        mis_d   = mis_q;
        case (state_q)
            StEntry: begin
                if (relock) begin
                    // Abort: the partial attempt is not counted as a failure
                    dc_d  = '0;
                    mis_d = 1'b0;
                end else if (digit_valid) begin
                    if (last_digit) begin
                        dc_d  = '0;
                        mis_d = 1'b0;
                        if (!(mis_q || digit_miss)) begin
                            state_d = StOpen;
                            fc_d    = '0;
                        end else if (fails_inc < 32'(MAX_FAILS)) begin
                            state_d = StError;
                            fc_d    = fc_q + FW'(1);
                        end else begin
                            state_d = StLockout;
                            fc_d    = FW'(MAX_FAILS);
                            timer_d = TW'(LOCKOUT_CYCLES - 1);
                        end
                    end else begin
                        dc_d  = dc_q + CW'(1);
                        mis_d = mis_q | digit_miss;
                    end
                end
            end
            StOpen, StError: begin
                if (relock) begin
                    state_d = StEntry;
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d = StEntry;
                    fc_d    = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = StEntry;
            end
        endcase
    end

    // State and flag registers; flags are registered from the next state so
    // every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StEntry;
            dc_q      <= '0;
            fc_q      <= '0;
            timer_q   <= '0;
            mis_q     <= 1'b0;
            open_q    <= 1'b0;
            error_q   <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dc_q      <= dc_d;
            fc_q      <= fc_d;
            timer_q   <= timer_d;
            mis_q     <= mis_d;
            open_q    <= (state_d == StOpen);
            error_q   <= (state_d == StError);
            lockout_q <= (state_d == StLockout);
        end
    end

    assign open        = open_q;
    assign error       = error_q;
    assign lockout     = lockout_q;
    assign digit_count = dc_q;
    assign fail_count  = fc_q;
    assign state       = state_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Scoreboard bench for combo_lock_fsm: a default instance (A) and a re-parametrised
// instance (B: 4 digits of 3 bits, 1 allowed failure, 5 lockout cycles). A
// sequence-level reference model predicts the outputs after every clock edge.
module tb_combo_lock_fsm;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults)
    logic        rn_a, dv_a, rl_a;
    logic [3:0]  din_a;
    logic [23:0] code_a;
    logic        open_a, error_a, lock_a;
    logic [2:0]  dc_a;
    logic [1:0]  fc_a;
    logic [1:0]  st_a;

    // Instance B (re-parametrised)
    logic        rn_b, dv_b, rl_b;
    logic [2:0]  din_b;
    logic [11:0] code_b;
    logic        open_b, error_b, lock_b;
    logic [2:0]  dc_b;
    logic [0:0]  fc_b;
    logic [1:0]  st_b;

    combo_lock_fsm dut_a (
        .clk         (clk),
        .reset_n     (rn_a),
        .digit_in    (din_a),
        .digit_valid (dv_a),
        .code        (code_a),
        .relock      (rl_a),
        .open        (open_a),
        .error       (error_a),
        .lockout     (lock_a),
        .digit_count (dc_a),
        .fail_count  (fc_a),
        .state       (st_a)
    );

    combo_lock_fsm #(
        .DIGITS         (4),
        .DIGIT_W        (3),
        .MAX_FAILS      (1),
        .LOCKOUT_CYCLES (5)
    ) dut_b (
        .clk         (clk),
        .reset_n     (rn_b),
        .digit_in    (din_b),
        .digit_valid (dv_b),
        .code        (code_b),
        .relock      (rl_b),
        .open        (open_b),
        .error       (error_b),
        .lockout     (lock_b),
        .digit_count (dc_b),
        .fail_count  (fc_b),
        .state       (st_b)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       o;
        logic       e;
        logic       l;
        logic [7:0] dc;
        logic [7:0] fc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks   = 0;
    int failures = 0;

    // Model parameters per instance
    int p_digits[2] = '{6, 4};
    int p_dw[2]     = '{4, 3};
    int p_maxf[2]   = '{3, 1};
    int p_lock[2]   = '{16, 5};
    longint unsigned p_code[2] = '{64'h654321, 64'o7012};

    // Model state: mode 0=entry 1=open 2=error 3=lockout
    int m_mode[2];
    int m_cnt[2];
    int m_fails[2];
    int m_left[2];
    int m_ent[2][8];

    // Staged stimulus applied on the next tick
    bit s_rst[2];
    bit s_dv[2];
    bit s_rl[2];
    int s_din[2];

    function automatic int code_digit(input int d, input int i);
        return int'((p_code[d] >> (i * p_dw[d])) & ((64'd1 << p_dw[d]) - 64'd1));
    endfunction

    task automatic model_step(input int d, input bit rst, input bit dv, input int din,
                              input bit rl);
        bit ok;
        if (rst) begin
            m_mode[d]  = 0;
            m_cnt[d]   = 0;
            m_fails[d] = 0;
            m_left[d]  = 0;
            return;
        end
        case (m_mode[d])
            0: begin
                if (rl) begin
                    m_cnt[d] = 0;
                end else if (dv) begin
                    m_ent[d][m_cnt[d]] = din;
                    m_cnt[d]++;
                    if (m_cnt[d] == p_digits[d]) begin
                        ok = 1'b1;
                        for (int i = 0; i < p_digits[d]; i++)
                            if (m_ent[d][i] != code_digit(d, i)) ok = 1'b0;
                        m_cnt[d] = 0;
                        if (ok) begin
                            m_mode[d]  = 1;
                            m_fails[d] = 0;
                        end else begin
                            m_fails[d]++;
                            if (m_fails[d] >= p_maxf[d]) begin
                                m_mode[d] = 3;
                                m_left[d] = p_lock[d];
                            end else begin
                                m_mode[d] = 2;
                            end
                        end
                    end
                end
            end
            1, 2: if (rl) m_mode[d] = 0;
            default: begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_mode[d]  = 0;
                    m_fails[d] = 0;
                end
            end
        endcase
    endtask

    function automatic exp_t model_exp(input int d);
        exp_t e;
        e.st = 2'(m_mode[d]);
        e.o  = (m_mode[d] == 1);
        e.e  = (m_mode[d] == 2);
        e.l  = (m_mode[d] == 3);
        e.dc = 8'(m_cnt[d]);
        e.fc = 8'(m_fails[d]);
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        rn_a  = !s_rst[0];
        dv_a  = s_dv[0];
        din_a = 4'(s_din[0]);
        rl_a  = s_rl[0];
        rn_b  = !s_rst[1];
        dv_b  = s_dv[1];
        din_b = 3'(s_din[1]);
        rl_b  = s_rl[1];
        for (int d = 0; d < 2; d++) begin
            model_step(d, s_rst[d], s_dv[d], s_din[d], s_rl[d]);
            s_rst[d] = 1'b0;
            s_dv[d]  = 1'b0;
            s_rl[d]  = 1'b0;
            s_din[d] = 0;
        end
        qa.push_back(model_exp(0));
        qb.push_back(model_exp(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic enter(input int d, input int v);
        s_dv[d]  = 1'b1;
        s_din[d] = v;
        tick();
    endtask

    task automatic relock_tick(input int d);
        s_rl[d] = 1'b1;
        tick();
    endtask

    task automatic enter_seq(input int d, input int v[6], input int n);
        for (int i = 0; i < n; i++) enter(d, v[i]);
    endtask

    task automatic compare(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual st=%0d open=%0b err=%0b lock=%0b dc=%0d fc=%0d required st=%0d open=%0b err=%0b lock=%0b dc=%0d fc=%0d",
                     name, $time, act.st, act.o, act.e, act.l, act.dc, act.fc,
                     exp.st, exp.o, exp.e, exp.l, exp.dc, exp.fc);
        end
    endtask

    // Monitor: every edge the DUTs present a new output set; pop and compare
    initial begin
        exp_t ea, eb, aa, ab;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                aa = {st_a, open_a, error_a, lock_a, 8'(dc_a), 8'(fc_a)};
                compare("dut_a", aa, ea);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                ab = {st_b, open_b, error_b, lock_b, 8'(dc_b), 8'(fc_b)};
                compare("dut_b", ab, eb);
            end
        end
    end

    initial begin
        int good_a[6]  = '{1, 2, 3, 4, 5, 6};
        int bad_a[6]   = '{1, 2, 3, 4, 5, 7};
        int bad2_a[6]  = '{9, 2, 3, 4, 5, 6};
        int good_b[6]  = '{2, 1, 0, 7, 0, 0};
        int bad_b[6]   = '{2, 1, 0, 6, 0, 0};
        code_a = 24'h654321;
        code_b = 12'o7012;
        rn_a = 1'b0; dv_a = 1'b0; rl_a = 1'b0; din_a = '0;
        rn_b = 1'b0; dv_b = 1'b0; rl_b = 1'b0; din_b = '0;
        for (int d = 0; d < 2; d++) begin
            s_rst[d] = 1'b0; s_dv[d] = 1'b0; s_rl[d] = 1'b0; s_din[d] = 0;
            m_mode[d] = 0; m_cnt[d] = 0; m_fails[d] = 0; m_left[d] = 0;
        end

        // Reset both instances
        s_rst[0] = 1'b1; s_rst[1] = 1'b1; tick();
        s_rst[0] = 1'b1; s_rst[1] = 1'b1; tick();

        // Correct code opens; wrong code errors; relock keeps the fail count
        enter_seq(0, good_a, 6);
        idle(2);
        relock_tick(0);
        enter_seq(0, bad_a, 6);
        idle(2);
        relock_tick(0);
        idle(1);

        // Two more failures reach lockout; digits and relock are ignored there
        enter_seq(0, bad2_a, 6);
        relock_tick(0);
        enter_seq(0, bad_a, 6);
        for (int i = 0; i < 18; i++) begin
            s_dv[0]  = 1'b1;
            s_din[0] = good_a[i % 6];
            s_rl[0]  = (i % 3 == 0);
            tick();
        end
        idle(2);

        // Relock and digit on the same edge: relock wins, digit discarded
        enter_seq(0, good_a, 3);
        s_rl[0] = 1'b1; s_dv[0] = 1'b1; s_din[0] = 4;
        tick();
        enter_seq(0, good_a, 6);
        relock_tick(0);

        // Reset mid-lockout and mid-attempt
        for (int k = 0; k < 3; k++) begin
            enter_seq(0, bad_a, 6);
            relock_tick(0);
        end
        idle(5);
        s_rst[0] = 1'b1; tick();
        enter_seq(0, good_a, 6);
        relock_tick(0);
        enter_seq(0, good_a, 4);
        s_rst[0] = 1'b1; tick();
        enter_seq(0, good_a, 6);
        relock_tick(0);

        // Re-parametrised instance: open, then one failure goes straight to lockout
        enter_seq(1, good_b, 4);
        idle(1);
        relock_tick(1);
        enter_seq(1, bad_b, 4);
        idle(7);
        enter_seq(1, good_b, 4);
        relock_tick(1);

        // Randomised traffic on both instances, biased toward correct digits
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                s_dv[d] = ($urandom_range(0, 99) < 45);
                if ($urandom_range(0, 3) != 0)
                    s_din[d] = code_digit(d, m_cnt[d]);
                else
                    s_din[d] = int'($urandom_range(0, (1 << p_dw[d]) - 1));
                s_rl[d]  = ($urandom_range(0, 99) < 6);
                s_rst[d] = ($urandom_range(0, 199) == 0);
            end
            tick();
        end
        idle(2);

        // Scoreboard must drain: one pop per edge
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d required=0/0", qa.size(), qb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
